// File: rtl/bypass_pkg.sv
// Shared types and constants for the EX result pipeline and operand bypass.
package bypass_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned N_ENT = 6;  // EX.b, EX.a, MEM.b, MEM.a, WB.b, WB.a
    localparam int unsigned N_EX  = 2;  // first N_EX entries are the EX stage
    localparam int unsigned N_OPS = 4;  // ID source operands

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [RA_W-1:0] rd;
        logic            is_load;
        logic [XLEN-1:0] data;
    } fwd_entry_t;

    // An entry can supply a value only if it really writes a non-zero register.
    function automatic logic is_live(input fwd_entry_t e);
        return e.valid & e.we & (e.rd != '0);
    endfunction

    // A load's result replaces its ALU data once the load data is available in MEM.
    function automatic fwd_entry_t with_load_data(input fwd_entry_t e,
                                                  input logic [XLEN-1:0] ld_data);
        fwd_entry_t r;
        r = e;
        if (e.is_load) begin
            r.data = ld_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// One operand's forwarding mux: youngest live match wins, else register file.
module fwd_sel
    import bypass_pkg::*;
(
    input  logic [RA_W-1:0] rs_i,
    input  logic [XLEN-1:0] rf_rdata_i,
    input  fwd_entry_t      ent_i [N_ENT],
    output logic [XLEN-1:0] data_o,
    output logic            load_hit_o
);

    // Scan oldest to youngest so the youngest match overwrites; r0 always reads 0.
    always_comb begin
        data_o     = rf_rdata_i;
        load_hit_o = 1'b0;
        for (int i = int'(N_ENT) - 1; i >= 0; i--) begin
            if (is_live(ent_i[i]) && (ent_i[i].rd == rs_i)) begin
                data_o     = ent_i[i].data;
                load_hit_o = (i < int'(N_EX)) && ent_i[i].is_load;
            end
        end
        if (rs_i == '0) begin
            data_o     = '0;
            load_hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/ex_result_bypass.sv
// Dual-slot EX->MEM->WB result pipeline with forwarding to the four ID operands.
module ex_result_bypass
    import bypass_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            EX_stall,
    input  logic            EX_valid_a,
    input  logic            EX_valid_b,
    input  logic            EX_we_a,
    input  logic            EX_we_b,
    input  logic [RA_W-1:0] EX_rd_a,
    input  logic [RA_W-1:0] EX_rd_b,
    input  logic            EX_is_load_a,
    input  logic            EX_is_load_b,
    input  logic [XLEN-1:0] EX_alu_result_a,
    input  logic [XLEN-1:0] EX_alu_result_b,
    input  logic            EX_flush_b,
    input  logic [XLEN-1:0] MEM_ld_data_a,
    input  logic [XLEN-1:0] MEM_ld_data_b,
    input  logic [RA_W-1:0] ID_rs_a1,
    input  logic [RA_W-1:0] ID_rs_a2,
    input  logic [RA_W-1:0] ID_rs_b1,
    input  logic [RA_W-1:0] ID_rs_b2,
    input  logic [XLEN-1:0] ID_rf_rdata_a1,
    input  logic [XLEN-1:0] ID_rf_rdata_a2,
    input  logic [XLEN-1:0] ID_rf_rdata_b1,
    input  logic [XLEN-1:0] ID_rf_rdata_b2,
    output logic [XLEN-1:0] ID_fwd_rdata_a1,
    output logic [XLEN-1:0] ID_fwd_rdata_a2,
    output logic [XLEN-1:0] ID_fwd_rdata_b1,
    output logic [XLEN-1:0] ID_fwd_rdata_b2,
    output logic            ID_load_use_stall,
    output logic            WB_we_a,
    output logic            WB_we_b,
    output logic [RA_W-1:0] WB_rd_a,
    output logic [RA_W-1:0] WB_rd_b,
    output logic [XLEN-1:0] WB_wdata_a,
    output logic [XLEN-1:0] WB_wdata_b
);

    fwd_entry_t ex_a, ex_b;
    fwd_entry_t mem_a_q, mem_a_d, mem_b_q, mem_b_d;
    fwd_entry_t wb_a_q, wb_a_d, wb_b_q, wb_b_d;
    fwd_entry_t mem_a_fwd, mem_b_fwd;
    fwd_entry_t ents [N_ENT];

    logic [RA_W-1:0] rs       [N_OPS];
    logic [XLEN-1:0] rf_rdata [N_OPS];
    logic [XLEN-1:0] fwd      [N_OPS];
    logic [N_OPS-1:0] load_hit;

    // EX bundle as entries; a flushed slot B is never live.
    always_comb begin
        ex_a = '{valid: EX_valid_a, we: EX_we_a, rd: EX_rd_a,
                 is_load: EX_is_load_a, data: EX_alu_result_a};
        ex_b = '{valid: EX_valid_b & ~EX_flush_b, we: EX_we_b, rd: EX_rd_b,
                 is_load: EX_is_load_b, data: EX_alu_result_b};
    end

    // MEM entries with load data substituted: feeds both forwarding and WB capture.
    always_comb begin
        mem_a_fwd = with_load_data(mem_a_q, MEM_ld_data_a);
        mem_b_fwd = with_load_data(mem_b_q, MEM_ld_data_b);
    end

    // Advance MEM and WB on non-stalled cycles; hold otherwise.
    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        wb_a_d  = wb_a_q;
        wb_b_d  = wb_b_q;
        if (!EX_stall) begin
            mem_a_d = ex_a;
            mem_b_d = ex_b;
            wb_a_d  = mem_a_fwd;
            wb_b_d  = mem_b_fwd;
        end
    end

    // Stage registers; reset discards everything in flight and wins over stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_a_q <= '0;
            mem_b_q <= '0;
            wb_a_q  <= '0;
            wb_b_q  <= '0;
        end else begin
            mem_a_q <= mem_a_d;
            mem_b_q <= mem_b_d;
            wb_a_q  <= wb_a_d;
            wb_b_q  <= wb_b_d;
        end
    end

    // Candidate list in forwarding priority order, youngest first.
    always_comb begin
        ents[0] = ex_b;
        ents[1] = ex_a;
        ents[2] = mem_b_fwd;
        ents[3] = mem_a_fwd;
        ents[4] = wb_b_q;
        ents[5] = wb_a_q;
    end

    // Flatten the four ID operands for the per-operand selectors.
    always_comb begin
        rs[0]       = ID_rs_a1;
        rs[1]       = ID_rs_a2;
        rs[2]       = ID_rs_b1;
        rs[3]       = ID_rs_b2;
        rf_rdata[0] = ID_rf_rdata_a1;
        rf_rdata[1] = ID_rf_rdata_a2;
        rf_rdata[2] = ID_rf_rdata_b1;
        rf_rdata[3] = ID_rf_rdata_b2;
    end

    for (genvar g = 0; g < int'(N_OPS); g++) begin : g_sel
        fwd_sel u_fwd_sel (
            .rs_i       (rs[g]),
            .rf_rdata_i (rf_rdata[g]),
            .ent_i      (ents),
            .data_o     (fwd[g]),
            .load_hit_o (load_hit[g])
        );
    end

    // Operand outputs, load-use stall and register-file write ports.
    always_comb begin
        ID_fwd_rdata_a1   = fwd[0];
        ID_fwd_rdata_a2   = fwd[1];
        ID_fwd_rdata_b1   = fwd[2];
        ID_fwd_rdata_b2   = fwd[3];
        ID_load_use_stall = |load_hit;
        WB_we_a           = is_live(wb_a_q);
        WB_we_b           = is_live(wb_b_q);
        WB_rd_a           = wb_a_q.rd;
        WB_rd_b           = wb_b_q.rd;
        WB_wdata_a        = wb_a_q.data;
        WB_wdata_b        = wb_b_q.data;
    end

endmodule

// File: tb/tb_ex_result_bypass.sv
// Self-checking bench for ex_result_bypass: directed scenarios plus random vs. model.
module tb_ex_result_bypass;

    logic        clk = 1'b0;
    logic        rstn;
    logic        EX_stall;
    logic        va, vb, wea, web, lda, ldb, flush;
    logic [4:0]  rda, rdb;
    logic [31:0] resa, resb, ldda, lddb;
    logic [4:0]  rs  [4];
    logic [31:0] rf  [4];
    logic [31:0] fwd [4];
    logic        lu_stall;
    logic        wb_we_a, wb_we_b;
    logic [4:0]  wb_rd_a, wb_rd_b;
    logic [31:0] wb_wd_a, wb_wd_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic        ld;
        logic [31:0] d;
    } ins_t;

    // Model: index 0 = bundle now in MEM, index 1 = bundle now in WB.
    ins_t pipe_a [2];
    ins_t pipe_b [2];

    always #5 clk = ~clk;

    ex_result_bypass dut (
        .clk(clk), .rstn(rstn), .EX_stall(EX_stall),
        .EX_valid_a(va), .EX_valid_b(vb), .EX_we_a(wea), .EX_we_b(web),
        .EX_rd_a(rda), .EX_rd_b(rdb), .EX_is_load_a(lda), .EX_is_load_b(ldb),
        .EX_alu_result_a(resa), .EX_alu_result_b(resb), .EX_flush_b(flush),
        .MEM_ld_data_a(ldda), .MEM_ld_data_b(lddb),
        .ID_rs_a1(rs[0]), .ID_rs_a2(rs[1]), .ID_rs_b1(rs[2]), .ID_rs_b2(rs[3]),
        .ID_rf_rdata_a1(rf[0]), .ID_rf_rdata_a2(rf[1]),
        .ID_rf_rdata_b1(rf[2]), .ID_rf_rdata_b2(rf[3]),
        .ID_fwd_rdata_a1(fwd[0]), .ID_fwd_rdata_a2(fwd[1]),
        .ID_fwd_rdata_b1(fwd[2]), .ID_fwd_rdata_b2(fwd[3]),
        .ID_load_use_stall(lu_stall),
        .WB_we_a(wb_we_a), .WB_we_b(wb_we_b),
        .WB_rd_a(wb_rd_a), .WB_rd_b(wb_rd_b),
        .WB_wdata_a(wb_wd_a), .WB_wdata_b(wb_wd_b)
    );

    task automatic clear_inputs();
        EX_stall = 0; va = 0; vb = 0; wea = 0; web = 0; lda = 0; ldb = 0; flush = 0;
        rda = 0; rdb = 0; resa = 0; resb = 0; ldda = 0; lddb = 0;
        for (int k = 0; k < 4; k++) begin
            rs[k] = 0;
            rf[k] = 0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 0;
        @(posedge clk);
        #1;
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk);
        #1;
        rs[0] = 5'd5;
        rf[0] = 32'h11;
        #1;
        n_vec++; if (wb_we_a !== 1'b0) begin n_err++; $display("FAIL reset_we_a: got %b want 0", wb_we_a); end
        n_vec++; if (wb_we_b !== 1'b0) begin n_err++; $display("FAIL reset_we_b: got %b want 0", wb_we_b); end
        n_vec++; if (wb_wd_a !== 32'h0 || wb_wd_b !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h/%h want 0/0", wb_wd_a, wb_wd_b); end
        n_vec++; if (wb_rd_a !== 5'd0 || wb_rd_b !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d/%0d want 0/0", wb_rd_a, wb_rd_b); end
        n_vec++; if (lu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", lu_stall); end
        n_vec++; if (fwd[0] !== 32'h11) begin n_err++; $display("FAIL reset_fwd_a1: got %h want 00000011", fwd[0]); end
    endtask

    task automatic test_same_rd();
        do_reset();
        va = 1; wea = 1; rda = 5'd3; resa = 32'hAAAA;
        vb = 1; web = 1; rdb = 5'd3; resb = 32'hBBBB;
        rs[3] = 5'd3; rf[3] = 32'h999;
        #1;
        n_vec++; if (fwd[3] !== 32'hBBBB) begin n_err++; $display("FAIL same_rd_fwd: got %h want 0000bbbb", fwd[3]); end
        @(posedge clk); #1;
        va = 0; vb = 0;
        @(posedge clk); #1;
        n_vec++; if (wb_we_a !== 1'b1 || wb_we_b !== 1'b1) begin n_err++; $display("FAIL same_rd_we: got %b%b want 11", wb_we_a, wb_we_b); end
        n_vec++; if (wb_wd_b !== 32'hBBBB || wb_wd_a !== 32'hAAAA) begin n_err++; $display("FAIL same_rd_wdata: got %h/%h want 0000aaaa/0000bbbb", wb_wd_a, wb_wd_b); end
        n_vec++; if (fwd[3] !== 32'hBBBB) begin n_err++; $display("FAIL same_rd_wb_fwd: got %h want 0000bbbb", fwd[3]); end
    endtask

    task automatic test_flush();
        do_reset();
        vb = 1; web = 1; rdb = 5'd7; resb = 32'h77; flush = 1;
        rs[0] = 5'd7; rf[0] = 32'h1234;
        #1;
        n_vec++; if (fwd[0] !== 32'h1234) begin n_err++; $display("FAIL flush_ex_fwd: got %h want 00001234", fwd[0]); end
        @(posedge clk); #1;
        vb = 0; flush = 0;
        #1;
        n_vec++; if (fwd[0] !== 32'h1234) begin n_err++; $display("FAIL flush_mem_fwd: got %h want 00001234", fwd[0]); end
        @(posedge clk); #1;
        n_vec++; if (wb_we_b !== 1'b0) begin n_err++; $display("FAIL flush_wb_we: got %b want 0", wb_we_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        va = 1; wea = 1; lda = 1; rda = 5'd9; resa = 32'h5555;
        rs[1] = 5'd9; rf[1] = 32'h42;
        #1;
        n_vec++; if (lu_stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %b want 1", lu_stall); end
        @(posedge clk); #1;
        va = 0; lda = 0; ldda = 32'hDEAD;
        #1;
        n_vec++; if (fwd[1] !== 32'hDEAD) begin n_err++; $display("FAIL load_mem_fwd: got %h want 0000dead", fwd[1]); end
        n_vec++; if (lu_stall !== 1'b0) begin n_err++; $display("FAIL load_stall_clear: got %b want 1'b0", lu_stall); end
        @(posedge clk); #1;
        ldda = 32'h0;
        #1;
        n_vec++; if (wb_wd_a !== 32'hDEAD || wb_we_a !== 1'b1) begin n_err++; $display("FAIL load_wb: got %h we %b want 0000dead we 1", wb_wd_a, wb_we_a); end
    endtask

    task automatic test_r0();
        do_reset();
        va = 1; wea = 1; rda = 5'd0; resa = 32'h5;
        rs[0] = 5'd0; rf[0] = 32'hFFFF;
        #1;
        n_vec++; if (fwd[0] !== 32'h0) begin n_err++; $display("FAIL r0_fwd: got %h want 0", fwd[0]); end
        @(posedge clk); #1;
        va = 0;
        @(posedge clk); #1;
        n_vec++; if (wb_we_a !== 1'b0) begin n_err++; $display("FAIL r0_wb_we: got %b want 0", wb_we_a); end
    endtask

    task automatic test_stall();
        do_reset();
        va = 1; wea = 1; rda = 5'd4; resa = 32'h44;
        @(posedge clk); #1;
        va = 0; EX_stall = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_vec++; if (wb_we_a !== 1'b0 || wb_rd_a !== 5'd0) begin n_err++; $display("FAIL stall_frozen%0d: got we %b rd %0d want 0/0", c, wb_we_a, wb_rd_a); end
        end
        EX_stall = 0;
        @(posedge clk); #1;
        n_vec++; if (wb_rd_a !== 5'd4 || wb_wd_a !== 32'h44 || wb_we_a !== 1'b1) begin n_err++; $display("FAIL stall_release: got rd %0d data %h we %b want 4/00000044/1", wb_rd_a, wb_wd_a, wb_we_a); end
    endtask

    task automatic test_random();
        ins_t c [6];
        logic [31:0] exp_d;
        logic        exp_hit, exp_stall, found;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            pipe_a[s] = '0;
            pipe_b[s] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rstn     = ($urandom_range(0, 29) != 0);
            EX_stall = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 4) == 0);
            va = 1'($urandom); vb = 1'($urandom);
            wea = ($urandom_range(0, 3) != 0); web = ($urandom_range(0, 3) != 0);
            lda = ($urandom_range(0, 3) == 0); ldb = ($urandom_range(0, 3) == 0);
            rda = 5'($urandom_range(0, 7)); rdb = 5'($urandom_range(0, 7));
            resa = $urandom; resb = $urandom; ldda = $urandom; lddb = $urandom;
            for (int k = 0; k < 4; k++) begin
                rs[k] = 5'($urandom_range(0, 7));
                rf[k] = $urandom;
            end
            #1;
            // Candidates youngest first; MEM loads already carry their load data.
            c[0] = '{v: vb & ~flush, we: web, rd: rdb, ld: ldb, d: resb};
            c[1] = '{v: va, we: wea, rd: rda, ld: lda, d: resa};
            c[2] = pipe_b[0];
            if (c[2].ld) c[2].d = lddb;
            c[3] = pipe_a[0];
            if (c[3].ld) c[3].d = ldda;
            c[4] = pipe_b[1];
            c[5] = pipe_a[1];
            exp_stall = 0;
            for (int k = 0; k < 4; k++) begin
                found = 0; exp_d = rf[k]; exp_hit = 0;
                for (int j = 0; j < 6; j++) begin
                    if (!found && c[j].v && c[j].we && c[j].rd != 0 && c[j].rd == rs[k]) begin
                        found = 1;
                        exp_d = c[j].d;
                        exp_hit = (j < 2) && c[j].ld;
                    end
                end
                if (rs[k] == 0) begin
                    exp_d = 0;
                    exp_hit = 0;
                end
                exp_stall = exp_stall | exp_hit;
                if (!exp_hit) begin
                    n_vec++;
                    if (fwd[k] !== exp_d) begin n_err++; $display("FAIL rnd_fwd%0d cyc %0d: got %h want %h", k, cyc, fwd[k], exp_d); end
                end
            end
            n_vec++; if (lu_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, lu_stall, exp_stall); end
            n_vec++; if (wb_we_a !== (pipe_a[1].v && pipe_a[1].we && pipe_a[1].rd != 0)) begin n_err++; $display("FAIL rnd_we_a cyc %0d: got %b", cyc, wb_we_a); end
            n_vec++; if (wb_we_b !== (pipe_b[1].v && pipe_b[1].we && pipe_b[1].rd != 0)) begin n_err++; $display("FAIL rnd_we_b cyc %0d: got %b", cyc, wb_we_b); end
            n_vec++; if (wb_rd_a !== pipe_a[1].rd || wb_wd_a !== pipe_a[1].d) begin n_err++; $display("FAIL rnd_wb_a cyc %0d: got %0d/%h want %0d/%h", cyc, wb_rd_a, wb_wd_a, pipe_a[1].rd, pipe_a[1].d); end
            n_vec++; if (wb_rd_b !== pipe_b[1].rd || wb_wd_b !== pipe_b[1].d) begin n_err++; $display("FAIL rnd_wb_b cyc %0d: got %0d/%h want %0d/%h", cyc, wb_rd_b, wb_wd_b, pipe_b[1].rd, pipe_b[1].d); end
            @(posedge clk);
            if (!rstn) begin
                for (int s = 0; s < 2; s++) begin
                    pipe_a[s] = '0;
                    pipe_b[s] = '0;
                end
            end else if (!EX_stall) begin
                pipe_b[1] = c[2];
                pipe_a[1] = c[3];
                pipe_b[0] = c[0];
                pipe_a[0] = c[1];
            end
            #1;
        end
        rstn = 1;
        clear_inputs();
    endtask

    initial begin
        rstn = 0;
        clear_inputs();
        test_reset();
        test_same_rd();
        test_flush();
        test_load_use();
        test_r0();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
